// File: rtl/i2c_shift_ctrl.sv
// Self-counting shift engine for I2C address/data bytes: parallel load, serial shift in
// either bit order, an internal bit counter, a one-cycle completion pulse, and abort.
module i2c_shift_ctrl #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1,
   parameter int CNT_W     = 6
) (
   input  logic             clk,
   input  logic             asyn_rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             start,
   input  logic             abort,
   input  logic             shift_en,
   input  logic             serial_in,
   output logic             serial_out,
   output logic [WIDTH-1:0] data_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] bit_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] shifted;

   always_ff @(posedge clk or posedge asyn_rst) begin
      if (asyn_rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      shifted = '0;
      if (MSB_FIRST != 0) begin
         shifted = {data_q[WIDTH-2:0], serial_in};
      end else begin
         shifted = {serial_in, data_q[WIDTH-1:1]};
      end
   end

   // Abort outranks load/start, which outrank the bit strobe; abort keeps the data.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      if (abort) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (load) begin
                  data_d = data_in;
               end
               if (start) begin
                  state_d = SHIFT;
                  cnt_d   = '0;
               end else if (state_q == DONE) begin
                  state_d = IDLE;
               end
            end
            SHIFT: begin
               if (shift_en) begin
                  data_d = shifted;
                  cnt_d  = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(WIDTH - 1)) begin
                     state_d = DONE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   assign serial_out = (MSB_FIRST != 0) ? data_q[WIDTH-1] : data_q[0];
   assign data_out   = data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign bit_cnt    = cnt_q;

endmodule

// File: doc/i2c_shift_ctrl.md
Name: i2c_shift_ctrl

Overview:
- Parametrised, self-counting shift engine for address and data bytes in I2C transmit and receive paths.
- Adds several features the fixed 8-bit shifter lacks:
  - configurable width and bit order;
  - synchronous parallel load;
  - an internal bit counter with a completion pulse;
  - abort.
- Sits between the byte-level controller (load, start, abort) and the SCL/SDA bit-timing logic (shift_en strobe, serial in/out).

Parameters:
- WIDTH, 8, shift register width in bits (legal range 2..32).
- MSB_FIRST, 1. 1 = transmit/receive MSB first (I2C); 0 = LSB first.
- CNT_W, 6, bit counter width. Must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- asyn_rst  input  1  reset: asynchronous, active-high.
- load  input  1  synchronous parallel load of data_in. Honoured only in IDLE or DONE.
- data_in  input  WIDTH  parallel load value.
- start  input  1  begin a WIDTH-bit shift sequence. Honoured only in IDLE or DONE.
- abort  input  1  terminate any sequence; return to IDLE.
- shift_en  input  1  one-cycle bit strobe from bit-timing logic.
- serial_in  input  1  receive bit, sampled on a shift_en cycle.
- serial_out  output  1  transmit bit: data[WIDTH-1] if MSB_FIRST, else data[0].
- data_out  output  WIDTH  current register contents.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; high in the DONE state only.
- bit_cnt  output  CNT_W  number of bits shifted in the current sequence.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - data=0, state=IDLE, bit_cnt=0, busy=0, done=0.
  - serial_out therefore reads 0.
- States:
  - IDLE: waiting.
  - SHIFT: counting bits.
  - DONE: one cycle only, then IDLE unless start is high.
- Priority per cycle, highest first: asyn_rst > abort > load/start > shift_en.
- abort (any state):
  - next state IDLE, bit_cnt=0, done=0.
  - data is held, not cleared.
  - A shift_en in the same cycle is ignored.
- load in IDLE/DONE: data <= data_in at the next edge.
- load in SHIFT is ignored; data is unaffected by load.
- start in IDLE/DONE: next state SHIFT, bit_cnt <= 0.
- load and start in the same cycle:
  - both take effect;
  - the first transmitted bit is the loaded bit, visible on serial_out the cycle after.
- start in DONE begins a new sequence back-to-back, with no IDLE cycle.
- shift_en in SHIFT:
  - MSB_FIRST=1: data <= {data[WIDTH-2:0], serial_in}.
  - MSB_FIRST=0: data <= {serial_in, data[WIDTH-1:1]}.
  - bit_cnt increments.
- Completion: a shift_en in SHIFT while bit_cnt == WIDTH-1 does all of the following:
  - performs the final shift;
  - sets bit_cnt = WIDTH;
  - next state DONE.
  - done is high for exactly that one following cycle.
- bit_cnt:
  - holds WIDTH through DONE;
  - cleared on start or abort;
  - otherwise held in IDLE;
  - never wraps.
- shift_en outside SHIFT: ignored, with no change to data or bit_cnt.
- Latency:
  - serial_out and data_out update one cycle after the qualifying edge input.
  - done asserts the cycle after the last shift_en.
- busy = (state == SHIFT). busy and done are registered and glitch-free.
- The data register is clocked by clk only; there is no asynchronous load path.

Test Plan:
- Reset mid-SHIFT, after 3 bits of 0xA5 → next edge shows data_out=0, bit_cnt=0, busy=0, done=0, serial_out=0.
- TX, MSB_FIRST=1, WIDTH=8:
  - stimulus: load 0xA5 + start in the same cycle, then 8 shift_en with serial_in=0;
  - required: serial_out sequence 1,0,1,0,0,1,0,1; done pulses once after the 8th strobe; data_out=0x00; bit_cnt=8.
- RX, MSB_FIRST=1: start, then serial_in 1,1,0,0,1,0,1,0 on 8 strobes → data_out=0xCA, done for 1 cycle, busy falls on the same edge that done rises.
- LSB_FIRST build (MSB_FIRST=0, WIDTH=10): load 0x2B3, start, 10 strobes → serial_out emits 1,1,0,0,1,1,0,1,0,1; done after strobe 10; bit_cnt=10.
- Abort after 5 strobes, with shift_en asserted in the same cycle:
  - state returns to IDLE, bit_cnt=0, no done;
  - data_out equals the value after 5 shifts;
  - later shift_en strobes change nothing.
- Ignored inputs and back-to-back:
  - load 0xFF during SHIFT → data not overwritten;
  - start asserted in the DONE cycle → SHIFT the next cycle with bit_cnt=0 and no IDLE cycle;
  - shift_en while IDLE → no change.
